// File: rtl/sobel4dir_core.sv
// rtl/sobel4dir_core.sv - four-direction Sobel edge stage, 3x3 window in, binary edge pixel out
//
// Purpose:
//   Takes one 3x3 window per beat and computes four gradients: 0, 90, 45 and 135 degrees.
//   It compares the sum of their squares with THRESH and emits EDGE_VAL or BG_VAL.
//   The stage is a three-deep pipeline with valid/ready on both sides and one global advance enable.
//   It sustains one pixel per clock while downstream is ready.
//
// Ports:
//   s_aclk         in   1   clock
//   s_areset       in   1   synchronous reset, active-high
//   s_axis_tvalid  in   1   window beat valid
//   s_axis_tready  out  1   stage accepts a window this cycle
//   s_axis_tdata   in   72  window p0..p8 row-major, p0 = [7:0] top-left, p8 = [71:64]
//   s_axis_tuser   in   1   start of frame, travels with the pixel
//   s_axis_tlast   in   1   end of line, travels with the pixel
//   m_axis_tvalid  out  1   edge pixel valid
//   m_axis_tready  in   1   downstream ready
//   m_axis_tdata   out  8   EDGE_VAL or BG_VAL
//   m_axis_tuser   out  1   delayed s_axis_tuser
//   m_axis_tlast   out  1   delayed s_axis_tlast

module sobel4dir_core #(
  parameter logic [21:0] THRESH   = 22'd4000,
  parameter logic [7:0]  EDGE_VAL = 8'hFF,
  parameter logic [7:0]  BG_VAL   = 8'h00
) (
  input  logic        s_aclk,
  input  logic        s_areset,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [71:0] s_axis_tdata,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast
);

  // Weighted three-tap difference: (a + 2b + c) - (d + 2e + f).
  // Each side is at most 1020, so both sides fit 11 bits unsigned.
  // The difference wraps correctly into signed 11 bits (range +/-1020).
  function automatic logic signed [10:0] kern(
    input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
    input logic [7:0] d, input logic [7:0] e, input logic [7:0] f
  );
    logic [10:0] pos;
    logic [10:0] neg;
    pos = {3'b000, a} + {2'b00, b, 1'b0} + {3'b000, c};
    neg = {3'b000, d} + {2'b00, e, 1'b0} + {3'b000, f};
    return $signed(pos - neg);
  endfunction

  // Square of a gradient.
  // The magnitude never exceeds 1020, so the negation only needs the low 10 bits.
  function automatic logic [19:0] square(input logic signed [10:0] g);
    logic [9:0] mag;
    mag = g[10] ? (~g[9:0] + 10'd1) : g[9:0];
    return 20'(mag) * 20'(mag);
  endfunction

  // Every stage shifts together when the output slot is empty or being drained.
  logic en;
  assign en            = ~m_axis_tvalid | m_axis_tready;
  assign s_axis_tready = en;

  logic [7:0] p [0:8];

  always_comb begin
    for (int i = 0; i < 9; i++) begin
      p[i] = s_axis_tdata[8*i +: 8];
    end
  end

  logic signed [10:0] gx_c;
  logic signed [10:0] gy_c;
  logic signed [10:0] g45_c;
  logic signed [10:0] g135_c;

  assign gx_c   = kern(p[2], p[5], p[8], p[0], p[3], p[6]);
  assign gy_c   = kern(p[6], p[7], p[8], p[0], p[1], p[2]);
  assign g45_c  = kern(p[1], p[2], p[5], p[3], p[6], p[7]);
  assign g135_c = kern(p[1], p[0], p[3], p[5], p[8], p[7]);

  // Stage 1: gradients
  logic               s1_valid;
  logic               s1_user;
  logic               s1_last;
  logic signed [10:0] s1_gx;
  logic signed [10:0] s1_gy;
  logic signed [10:0] s1_g45;
  logic signed [10:0] s1_g135;

  // Stage 2: squares
  logic        s2_valid;
  logic        s2_user;
  logic        s2_last;
  logic [19:0] s2_sq_x;
  logic [19:0] s2_sq_y;
  logic [19:0] s2_sq_45;
  logic [19:0] s2_sq_135;

  // Stage 3 input: four 20-bit squares sum to at most 4161600, which fits 22 bits.
  logic [21:0] g2_sum;
  logic        edge_hit;

  assign g2_sum   = 22'(s2_sq_x) + 22'(s2_sq_y) + 22'(s2_sq_45) + 22'(s2_sq_135);
  assign edge_hit = g2_sum > THRESH;

  // Only the valid bits and the output registers are reset.
  // Datapath contents behind a cleared valid bit are never observed.
  always_ff @(posedge s_aclk) begin
    if (s_areset) begin
      s1_valid      <= 1'b0;
      s2_valid      <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= BG_VAL;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (en) begin
      // Sideband bits are qualified by valid, so bubbles never carry a stray tuser or tlast.
      s1_valid      <= s_axis_tvalid;
      s1_user       <= s_axis_tvalid & s_axis_tuser;
      s1_last       <= s_axis_tvalid & s_axis_tlast;
      s1_gx         <= gx_c;
      s1_gy         <= gy_c;
      s1_g45        <= g45_c;
      s1_g135       <= g135_c;

      s2_valid      <= s1_valid;
      s2_user       <= s1_user;
      s2_last       <= s1_last;
      s2_sq_x       <= square(s1_gx);
      s2_sq_y       <= square(s1_gy);
      s2_sq_45      <= square(s1_g45);
      s2_sq_135     <= square(s1_g135);

      m_axis_tvalid <= s2_valid;
      m_axis_tuser  <= s2_user;
      m_axis_tlast  <= s2_last;
      m_axis_tdata  <= edge_hit ? EDGE_VAL : BG_VAL;
    end
  end

endmodule

// File: tb/tb_sobel4dir_core.sv
// tb/tb_sobel4dir_core.sv - self-checking bench for sobel4dir_core

module tb_sobel4dir_core;

  logic        s_aclk = 1'b0;
  always #5 s_aclk = ~s_aclk;

  logic        s_areset;
  logic        s_tvalid;
  logic [71:0] s_tdata;
  logic        s_tuser;
  logic        s_tlast;
  logic        m_tready;

  logic        s_tready_a, m_tvalid_a, m_tuser_a, m_tlast_a;
  logic [7:0]  m_tdata_a;
  logic        s_tready_b, m_tvalid_b, m_tuser_b, m_tlast_b;
  logic [7:0]  m_tdata_b;

  sobel4dir_core dut_a (
    .s_aclk        (s_aclk),
    .s_areset      (s_areset),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready_a),
    .s_axis_tdata  (s_tdata),
    .s_axis_tuser  (s_tuser),
    .s_axis_tlast  (s_tlast),
    .m_axis_tvalid (m_tvalid_a),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata_a),
    .m_axis_tuser  (m_tuser_a),
    .m_axis_tlast  (m_tlast_a)
  );

  sobel4dir_core #(.THRESH(22'd600)) dut_b (
    .s_aclk        (s_aclk),
    .s_areset      (s_areset),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready_b),
    .s_axis_tdata  (s_tdata),
    .s_axis_tuser  (s_tuser),
    .s_axis_tlast  (s_tlast),
    .m_axis_tvalid (m_tvalid_b),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata_b),
    .m_axis_tuser  (m_tuser_b),
    .m_axis_tlast  (m_tlast_b)
  );

  int n_check = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_check++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the Sobel kernels as 3x3 weight masks, evaluated as plain integer arithmetic.
  localparam int KX   [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
  localparam int KY   [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
  localparam int K45  [9] = '{0, 1, 2, -1, 0, 1, -2, -1, 0};
  localparam int K135 [9] = '{2, 1, 0, 1, 0, -1, 0, -1, -2};

  function automatic int grad2(input logic [71:0] w);
    int gx, gy, g45, g135, pix;
    gx = 0; gy = 0; g45 = 0; g135 = 0;
    for (int i = 0; i < 9; i++) begin
      pix   = int'(w[8*i +: 8]);
      gx   += KX[i] * pix;
      gy   += KY[i] * pix;
      g45  += K45[i] * pix;
      g135 += K135[i] * pix;
    end
    return gx*gx + gy*gy + g45*g45 + g135*g135;
  endfunction

  function automatic logic [7:0] ref_pix(input logic [71:0] w, input int thresh);
    return (grad2(w) > thresh) ? 8'hFF : 8'h00;
  endfunction

  function automatic logic [71:0] pack9(input int a0, input int a1, input int a2,
                                        input int a3, input int a4, input int a5,
                                        input int a6, input int a7, input int a8);
    return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  function automatic logic [71:0] rand_win();
    logic [71:0] w;
    int base, mode;
    mode = int'($urandom_range(0, 2));
    base = int'($urandom_range(0, 240));
    w = '0;
    for (int i = 0; i < 9; i++) begin
      if (mode == 0)      w[8*i +: 8] = 8'($urandom_range(0, 255));
      else if (mode == 1) w[8*i +: 8] = 8'(base + int'($urandom_range(0, 12)));
      else                w[8*i +: 8] = 8'((i == int'($urandom_range(0, 8))) ? $urandom_range(0, 30) : 0);
    end
    return w;
  endfunction

  // Scoreboard fed by the input handshake, drained by the output handshake.
  typedef struct {
    logic [7:0] da;
    logic [7:0] db;
    logic       user;
    logic       last;
  } exp_t;

  exp_t       sbq [$];
  exp_t       mon_e;
  int         cyc = 0;
  int         out_cnt = 0;
  int         acc_cnt = 0;
  int         disc_cnt = 0;
  int         out_cyc_q [$];
  logic       held = 1'b0;
  logic [9:0] held_val;

  always @(negedge s_aclk) begin
    cyc = cyc + 1;
    if (s_areset) begin
      disc_cnt = disc_cnt + sbq.size();
      sbq.delete();
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_valid", m_tvalid_a, 1);
        chk("hold_payload", {m_tdata_a, m_tuser_a, m_tlast_a}, held_val);
      end
      chk("s_tready_rule", s_tready_a, (!m_tvalid_a || m_tready));
      chk("b_tready_match", s_tready_b, s_tready_a);
      chk("b_tvalid_match", m_tvalid_b, m_tvalid_a);
      if (m_tvalid_a && m_tready) begin
        chk("sb_nonempty", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          mon_e = sbq.pop_front();
          chk("out_data_t4000", m_tdata_a, mon_e.da);
          chk("out_data_t600", m_tdata_b, mon_e.db);
          chk("out_tuser", m_tuser_a, mon_e.user);
          chk("out_tlast", m_tlast_a, mon_e.last);
          chk("b_tuser_tlast", {m_tuser_b, m_tlast_b}, {mon_e.user, mon_e.last});
          out_cnt = out_cnt + 1;
          out_cyc_q.push_back(cyc);
        end
      end
      if (s_tvalid && s_tready_a) begin
        mon_e.da   = ref_pix(s_tdata, 4000);
        mon_e.db   = ref_pix(s_tdata, 600);
        mon_e.user = s_tuser;
        mon_e.last = s_tlast;
        sbq.push_back(mon_e);
        acc_cnt = acc_cnt + 1;
      end
      held     = m_tvalid_a && !m_tready;
      held_val = {m_tdata_a, m_tuser_a, m_tlast_a};
    end
  end

  task automatic step();
    @(posedge s_aclk);
    #1;
  endtask

  task automatic drain(input string name);
    int c;
    c = 0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    while (sbq.size() != 0 && c < 100) begin
      step();
      c++;
    end
    chk(name, sbq.size(), 0);
  endtask

  // Sends n beats. tuser marks beat 0 and tlast marks every beat where k % last_mod == last_mod-1.
  // A deterministic stall is applied with stall_len cycles starting at cycle stall_at.
  // When rnd is set, the bench randomizes source gaps and downstream backpressure instead.
  task automatic run_stream(input int n, input int stall_at, input int stall_len,
                            input int last_mod, input bit rnd);
    int  sent, c;
    bit  acc;
    logic [71:0] cur;
    sent = 0;
    c    = 0;
    cur  = rand_win();
    while (sent < n && c < 4000) begin
      if (rnd) m_tready = ($urandom_range(0, 3) != 0);
      else     m_tready = !(c >= stall_at && c < stall_at + stall_len);
      if (rnd && $urandom_range(0, 4) == 0) begin
        s_tvalid = 1'b0;
      end else begin
        s_tvalid = 1'b1;
        s_tdata  = cur;
        s_tuser  = (sent == 0);
        s_tlast  = ((sent % last_mod) == last_mod - 1);
      end
      #1;
      if (!rnd && m_tvalid_a && !m_tready) chk("stall_tready_low", s_tready_a, 0);
      acc = s_tvalid && s_tready_a;
      step();
      if (acc) begin
        sent++;
        cur = rand_win();
      end
      c++;
    end
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
    chk("stream_all_sent", sent, n);
  endtask

  typedef struct {
    string       name;
    logic [71:0] win;
    logic [7:0]  ea;
    logic [7:0]  eb;
  } vec_t;

  vec_t vq [$];

  task automatic add_vec(input string name, input logic [71:0] win,
                         input logic [7:0] ea, input logic [7:0] eb);
    vec_t v;
    v.name = name;
    v.win  = win;
    v.ea   = ea;
    v.eb   = eb;
    vq.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base_out;

    s_areset = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;

    // Expected outputs are listed for THRESH=4000 (ea) and THRESH=600 (eb).
    add_vec("flat80",      pack9(128,128,128,128,128,128,128,128,128), 8'h00, 8'h00);
    add_vec("all_zero",    pack9(0,0,0,0,0,0,0,0,0),                   8'h00, 8'h00);
    add_vec("vert_edge",   pack9(0,255,255,0,255,255,0,255,255),       8'hFF, 8'hFF);
    add_vec("horiz_edge",  pack9(0,0,0,0,0,0,255,255,255),             8'hFF, 8'hFF);
    add_vec("p5_10_g600",  pack9(0,0,0,0,0,10,0,0,0),                  8'h00, 8'h00);
    add_vec("p5_11_g726",  pack9(0,0,0,0,0,11,0,0,0),                  8'h00, 8'hFF);
    add_vec("p5_25_g3750", pack9(0,0,0,0,0,25,0,0,0),                  8'h00, 8'hFF);
    add_vec("p5_26_g4056", pack9(0,0,0,0,0,26,0,0,0),                  8'hFF, 8'hFF);

    step();
    step();
    s_areset = 1'b0;
    chk("rst_tvalid", m_tvalid_a, 0);
    chk("rst_tdata", m_tdata_a, 8'h00);
    chk("rst_tuser_tlast", {m_tuser_a, m_tlast_a}, 2'b00);
    chk("rst_s_tready", s_tready_a, 1);

    // Single beats checked for exact 3-cycle latency and the tabulated value.
    foreach (vq[i]) begin
      s_tvalid = 1'b1;
      s_tdata  = vq[i].win;
      #1;
      chk({vq[i].name, "_accept"}, s_tready_a, 1);
      step();
      s_tvalid = 1'b0;
      step();
      chk({vq[i].name, "_not_early"}, m_tvalid_a, 0);
      step();
      chk({vq[i].name, "_valid_at_3"}, m_tvalid_a, 1);
      chk({vq[i].name, "_t4000"}, m_tdata_a, vq[i].ea);
      chk({vq[i].name, "_t600"}, m_tdata_b, vq[i].eb);
      step();
    end
    drain("table_drain");

    // Ten beats with five cycles of downstream stall in the middle.
    base_out = out_cnt;
    run_stream(10, 4, 5, 10, 1'b0);
    drain("stall_drain");
    chk("stall_out_count", out_cnt - base_out, 10);

    // Twenty beats at full rate; outputs must occupy consecutive cycles.
    base_out = out_cnt;
    out_cyc_q.delete();
    run_stream(20, 0, 0, 10, 1'b0);
    drain("rate_drain");
    chk("rate_out_count", out_cnt - base_out, 20);
    if (out_cyc_q.size() == 20) chk("rate_back_to_back", out_cyc_q[19] - out_cyc_q[0], 19);
    else chk("rate_out_cycles", out_cyc_q.size(), 20);

    // Reset with three beats in flight.
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = pack9(0,255,255,0,255,255,0,255,255);
      step();
    end
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    s_areset = 1'b1;
    #1;
    chk("inflight_present", m_tvalid_a, 1);
    base_out = out_cnt;
    step();
    s_areset = 1'b0;
    m_tready = 1'b1;
    chk("midrst_tvalid", m_tvalid_a, 0);
    chk("midrst_tdata", m_tdata_a, 8'h00);
    chk("midrst_s_tready", s_tready_a, 1);
    s_tvalid = 1'b1;
    s_tdata  = pack9(0,0,0,0,0,0,255,255,255);
    step();
    s_tvalid = 1'b0;
    step();
    chk("postrst_not_early", m_tvalid_a, 0);
    step();
    chk("postrst_valid_at_3", m_tvalid_a, 1);
    chk("postrst_data", m_tdata_a, 8'hFF);
    for (int i = 0; i < 5; i++) step();
    chk("postrst_single_out", out_cnt - base_out, 1);

    // Randomized traffic with bubbles and backpressure, checked by the scoreboard.
    run_stream(300, 0, 0, 16, 1'b1);
    drain("random_drain");

    chk("total_out_count", out_cnt, acc_cnt - disc_cnt);
    chk("discarded_inflight", disc_cnt, 3);

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
